// File: rtl/vedic_pkg.sv
// vedic_pkg: shared definitions for the sequential vedic multiplier.
//   state_t : FSM state encoding (IDLE / MUL / DONE)
//   clog2   : ceiling log2 used to size the nibble counters; never returns
//             less than 1 so a single-nibble operand still gets a 1-bit counter.
package vedic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/vedic4.sv
// vedic4: purely combinational 4x4 unsigned multiplier, vedic (urdhva
// tiryagbhyam) structure built from four 2x2 vedic blocks.
// Ports:
//   a, b : 4-bit unsigned operands
//   p    : 8-bit unsigned product a*b
module vedic4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  // 2x2 vedic block: vertical and crosswise partial products with half adders.
  function automatic logic [3:0] vedic2(input logic [1:0] x, input logic [1:0] y);
    logic p0;
    logic s1;
    logic c1;
    logic s2;
    logic c2;
    p0 = x[0] & y[0];
    s1 = (x[1] & y[0]) ^ (x[0] & y[1]);
    c1 = (x[1] & y[0]) & (x[0] & y[1]);
    s2 = (x[1] & y[1]) ^ c1;
    c2 = (x[1] & y[1]) & c1;
    return {c2, s2, s1, p0};
  endfunction

  logic [3:0] q_ll;
  logic [3:0] q_hl;
  logic [3:0] q_lh;
  logic [3:0] q_hh;

  assign q_ll = vedic2(a[1:0], b[1:0]);
  assign q_hl = vedic2(a[3:2], b[1:0]);
  assign q_lh = vedic2(a[1:0], b[3:2]);
  assign q_hh = vedic2(a[3:2], b[3:2]);

  // Crosswise terms weigh 4, the high-high term weighs 16.
  assign p = {4'b0000, q_ll}
           + {2'b00, q_hl, 2'b00}
           + {2'b00, q_lh, 2'b00}
           + {q_hh, 4'b0000};

endmodule

// File: rtl/vedic_seq_mul.sv
// vedic_seq_mul: multi-cycle WxW unsigned multiplier that walks all nibble
// pairs of the two operands through one shared vedic4 core and
// shift-accumulates the partial products.
// Ports:
//   clk, rst_n           : clock (rising edge), async active-low reset
//   ena                  : global enable, all state holds when low
//   in_valid / in_ready  : operand handshake (a, b sampled on acceptance)
//   out_valid / out_ready: product handshake
//   a, b                 : W-bit unsigned operands
//   product              : 2W-bit unsigned product, valid while out_valid
//   busy                 : high while multiplying or holding a result
module vedic_seq_mul
  import vedic_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product,
  output logic           busy
);

  localparam int K  = W / 4;
  localparam int IW = clog2(K);
  localparam logic [IW-1:0] LAST = IW'(K - 1);

  state_t         state;
  state_t         state_next;
  logic [IW-1:0]  i_idx;
  logic [IW-1:0]  j_idx;
  logic [IW-1:0]  i_next;
  logic [IW-1:0]  j_next;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic [W-1:0]   a_next;
  logic [W-1:0]   b_next;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] acc_next;
  logic [3:0]     a_nib;
  logic [3:0]     b_nib;
  logic [7:0]     pp;
  logic [IW:0]    nib_sum;
  logic [2*W-1:0] pp_shifted;

  assign a_nib = a_reg[{i_idx, 2'b00} +: 4];
  assign b_nib = b_reg[{j_idx, 2'b00} +: 4];

  vedic4 u_core (
    .a (a_nib),
    .b (b_nib),
    .p (pp)
  );

  // Partial product weight is 16^(i+j).
  assign nib_sum    = {1'b0, i_idx} + {1'b0, j_idx};
  assign pp_shifted = (2*W)'(pp) << {nib_sum, 2'b00};

  assign product = acc;

  // Next-state, index walk and accumulate.
  always_comb begin
    state_next = state;
    i_next     = i_idx;
    j_next     = j_idx;
    a_next     = a_reg;
    b_next     = b_reg;
    acc_next   = acc;
    case (state)
      ST_IDLE: begin
        // in_ready is high in IDLE, so in_valid alone completes the handshake.
        if (in_valid) begin
          state_next = ST_MUL;
          a_next     = a;
          b_next     = b;
          acc_next   = {(2*W){1'b0}};
          i_next     = {IW{1'b0}};
          j_next     = {IW{1'b0}};
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_MUL: begin
        acc_next = acc + pp_shifted;
        if (j_idx == LAST) begin
          j_next = {IW{1'b0}};
          if (i_idx == LAST) begin
            state_next = ST_DONE;
            i_next     = {IW{1'b0}};
          end else begin
            i_next = i_idx + IW'(1);
          end
        end else begin
          j_next = j_idx + IW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_DONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs; everything holds when ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      i_idx     <= {IW{1'b0}};
      j_idx     <= {IW{1'b0}};
      a_reg     <= {W{1'b0}};
      b_reg     <= {W{1'b0}};
      acc       <= {(2*W){1'b0}};
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (ena) begin
      state     <= state_next;
      i_idx     <= i_next;
      j_idx     <= j_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      acc       <= acc_next;
      in_ready  <= (state_next == ST_IDLE);
      out_valid <= (state_next == ST_DONE);
      busy      <= (state_next != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_vedic_seq_mul.sv
// tb_vedic_seq_mul: directed checks on a W=8 instance (reset, latency,
// backpressure, ena gating) plus randomized handshake sweeps on W=4 and
// W=16 instances, all checked against a queue of expected products.
module tb_vedic_seq_mul;

  logic clk = 1'b0;
  logic rst_n;

  // W=8 instance
  logic        ena;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  // W=4 instance
  logic        ena_sw;
  logic        in_valid4;
  logic        in_ready4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        out_valid4;
  logic        out_ready4;
  logic [7:0]  product4;
  logic        busy4;

  // W=16 instance
  logic        in_valid16;
  logic        in_ready16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        out_valid16;
  logic        out_ready16;
  logic [31:0] product16;
  logic        busy16;

  int compared = 0;
  int mismatched = 0;

  logic [15:0] sb8[$];
  logic [7:0]  sb4[$];
  logic [31:0] sb16[$];

  always #5 clk = ~clk;

  vedic_seq_mul #(.W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
  );

  vedic_seq_mul #(.W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .ena(ena_sw), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4), .product(product4), .busy(busy4)
  );

  vedic_seq_mul #(.W(16)) u16 (
    .clk(clk), .rst_n(rst_n), .ena(ena_sw), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16), .product(product16), .busy(busy16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One W=8 transaction, starting at a negedge with the DUT idle.
  task automatic run8(input logic [7:0] x, input logic [7:0] y,
                      input int stall_at, input int stall_len, input int bp);
    logic [15:0] exp_p;
    logic [15:0] held;
    int cnt;
    held = 16'h0000;
    check("in_ready_idle", in_ready, 1);
    a = x;
    b = y;
    in_valid = 1'b1;
    out_ready = (bp == 0);
    sb8.push_back(16'(x) * 16'(y));
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    check("busy_mul", busy, 1);
    check("in_ready_mul", in_ready, 0);
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      ena = !(cnt >= stall_at && cnt < stall_at + stall_len);
      if (cnt == stall_at) held = product;
      @(negedge clk);
      cnt++;
      if (stall_len > 0 && cnt == stall_at + stall_len) check("acc_frozen", product, held);
    end
    ena = 1'b1;
    check("latency", cnt, 4 + stall_len);
    check("queue_has_entry", sb8.size() != 0, 1);
    exp_p = (sb8.size() != 0) ? sb8.pop_front() : 16'hxxxx;
    for (int k = 0; k < bp; k++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_product", product, exp_p);
      check("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    check("out_valid", out_valid, 1);
    check("in_ready_done", in_ready, 0);
    check("product", product, exp_p);
    @(negedge clk);
    check("handoff_out_valid", out_valid, 0);
    check("handoff_in_ready", in_ready, 1);
    check("handoff_busy", busy, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sent;
    int recv;
    int cyc;
    rst_n = 1'b0;
    ena = 1'b1;
    ena_sw = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = 8'h00;
    b = 8'h00;
    in_valid4 = 1'b0;
    out_ready4 = 1'b0;
    a4 = 4'h0;
    b4 = 4'h0;
    in_valid16 = 1'b0;
    out_ready16 = 1'b0;
    a16 = 16'h0000;
    b16 = 16'h0000;

    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", product, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    run8(8'hFF, 8'hFF, 100, 0, 0);
    run8(8'h3C, 8'hA5, 100, 0, 0);
    run8(8'h00, 8'h7F, 100, 0, 0);
    run8(8'h12, 8'h34, 100, 0, 10);
    run8(8'hFF, 8'h01, 2, 3, 0);

    // Reset in the middle of a multiply: async return, no result emitted.
    a = 8'hFF;
    b = 8'hFF;
    in_valid = 1'b1;
    sb8.push_back(16'hFE01);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_product", product, 16'h0000);
    sb8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("postrst_no_valid", out_valid, 0);
    end
    run8(8'hA7, 8'h5B, 100, 0, 0);

    // Random sweep, W=16.
    sent = 0;
    recv = 0;
    cyc = 0;
    while (recv < 1000 && cyc < 60000) begin
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      in_valid16 = (sent < 1000) && ($urandom_range(0, 3) != 0);
      out_ready16 = ($urandom_range(0, 3) != 0);
      if (in_valid16 && in_ready16) begin
        sb16.push_back(32'(a16) * 32'(b16));
        sent++;
      end
      if (out_valid16 && out_ready16) begin
        check("sweep16_queue_has_entry", sb16.size() != 0, 1);
        if (sb16.size() != 0) check("sweep16_product", product16, sb16.pop_front());
        recv++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid16 = 1'b0;
    out_ready16 = 1'b0;
    check("sweep16_received", recv, 1000);
    check("sweep16_left_over", sb16.size(), 0);

    // Random sweep, W=4.
    sent = 0;
    recv = 0;
    cyc = 0;
    while (recv < 1000 && cyc < 30000) begin
      a4 = 4'($urandom);
      b4 = 4'($urandom);
      in_valid4 = (sent < 1000) && ($urandom_range(0, 3) != 0);
      out_ready4 = ($urandom_range(0, 3) != 0);
      if (in_valid4 && in_ready4) begin
        sb4.push_back(8'(a4) * 8'(b4));
        sent++;
      end
      if (out_valid4 && out_ready4) begin
        check("sweep4_queue_has_entry", sb4.size() != 0, 1);
        if (sb4.size() != 0) check("sweep4_product", product4, sb4.pop_front());
        recv++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid4 = 1'b0;
    out_ready4 = 1'b0;
    check("sweep4_received", recv, 1000);
    check("sweep4_left_over", sb4.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
